iram_fifo_ctl_64x32: RTL and testbench
======================================

# iram_fifo_ctl_64x32

Synchronous FIFO controller that drives a 64x32 simple dual-port block RAM (one write port, one registered read port, one clock) and turns it into a 32-bit valid/ready stream FIFO. It sits around the RAM: it is the write-side producer of `ena`/`wea`/`addra`/`dia` and the read-side consumer of `dob`. It hides the RAM's one-cycle read latency behind a 2-entry output prefetch buffer, so it sustains one word per cycle in and out.

## Interface
Parameters: none (geometry fixed at 64 deep x 32 wide).

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  controller accepts a word this cycle
- `in_data`  in  32  write data
- `out_valid`  out  1  head word available
- `out_ready`  in  1  consumer takes the head word
- `out_data`  out  32  head word
- `level`  out  7  total words held (RAM + in-flight + buffer), 0..66
- `ram_ena`  out  1  RAM write-port enable
- `ram_wea`  out  1  RAM write enable
- `ram_addra`  out  6  RAM write address
- `ram_dia`  out  32  RAM write data
- `ram_enb`  out  1  RAM read enable
- `ram_addrb`  out  6  RAM read address
- `ram_dob`  in  32  RAM read data, valid the cycle after `ram_enb`
- `hwm`  out  7  high-watermark of `level` (only with `IRAM_FIFO_HWM_EN`)

## Operation
- State:
  - `wptr[5:0]`, `rptr[5:0]`
  - `ram_cnt[6:0]`: 0..64 words written but not yet read
  - `inflight`: a read was issued last cycle
  - 2-entry output buffer `buf[0..1]`, `buf_cnt[1:0]`
- Push = `in_valid & in_ready`. `in_ready = (ram_cnt != 64)`; it does not depend on `out_ready`.
- On push:
  - Drive `ram_ena = ram_wea = 1`, `ram_addra = wptr`; `ram_dia = in_data` (combinational pass-through).
  - `wptr` increments mod 64 (wraps 63->0).
- Pop = `out_valid & out_ready`. `out_valid = (buf_cnt != 0)`; `out_data = buf[0]`.
- On pop, `buf[1]` shifts to `buf[0]`.
- Read issue: `ram_enb = (ram_cnt != 0) & ((buf_cnt + inflight < 2) | (buf_cnt + inflight == 2 & pop))`.
- On read issue: `ram_addrb = rptr`, `rptr` increments mod 64, `inflight` is set next cycle.
- When `inflight`, `ram_dob` is written into the first free buffer slot after accounting for that cycle's pop.
- `ram_cnt` next = `ram_cnt + push - ram_enb`. `buf_cnt` next = `buf_cnt + inflight - pop`.
- `level = ram_cnt + inflight + buf_cnt`. Maximum capacity is 66 words.
- Simultaneous push and read issue never target the same address: `ram_cnt` counts only words committed on earlier edges.
- FIFO order is strict; no word is dropped or duplicated.

## Timing
- Reset values, applied asynchronously while `reset` is high:
  - `wptr = rptr = 0`, `ram_cnt = 0`, `inflight = 0`, `buf_cnt = 0`
  - `out_valid = 0`, `ram_ena = ram_wea = ram_enb = 0`
  - `ram_addra = ram_addrb = 0`, `level = 0`, `in_ready = 1`, `hwm = 0`
  - `out_data` is don't-care.
- Reset mid-operation: all held and in-flight words are discarded. `ram_dob` is ignored until a new read issues.
- Latency, word pushed in cycle t into an empty FIFO:
  - read issued in t+1
  - `ram_dob` valid in t+2
  - `out_valid` high with that word in t+3
- Throughput: with `out_ready` held high and continuous pushes, one pop per cycle after the initial 3-cycle fill.
- Full: `ram_cnt == 64` forces `in_ready` low. Push and read issue in the same cycle at full are impossible (`in_ready` is 0). A read issue at full raises `in_ready` in the next cycle.
- Empty: `out_valid` low. `out_ready` has no effect.
- Backpressure: `out_ready` low stops reads once `buf_cnt + inflight == 2`. Buffer contents hold stable.

## Configuration
- `IRAM_FIFO_HWM_EN` defined:
  - Port `hwm[6:0]` and its register exist.
  - Each cycle, `hwm <= max(hwm, level)`.
  - Cleared only by `reset`.
- Not defined: the `hwm` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push 0x00000001 in cycle 0 with `out_ready = 1` -> `out_valid` first high in cycle 3 with `out_data = 0x00000001`, `level` returns to 0 in cycle 4.
- Push 0..65 with `out_ready = 0` -> `in_ready` stays high through all 66 accepts, then low. `level = 66`, `ram_cnt = 64`, `buf_cnt = 2`. A push attempt while `in_ready` is low causes no `ram_ena`.
- From full, hold `out_ready = 1` -> 66 pops with data 0..65 in order. `in_ready` is high again the cycle after the first read issue.
- Stream 200 sequential words with `in_valid = out_ready = 1` -> after the fill, one pop per cycle with no gaps. Data is in order across both `wptr` and `rptr` wrap-arounds (63->0).
- Random `in_valid`/`out_ready` (50%), 10k words -> scoreboard match, `level` always equals pushes minus pops.
- Assert `reset` while `level = 10` with a read in flight -> all outputs at reset values immediately. After release, the next pushed word 0xA5A5A5A5 is the first popped. With `IRAM_FIFO_HWM_EN`, `hwm` reads 0 after reset and 66 after the full-fill scenario.

Source files
------------

// File: rtl/iram_fifo_ctl_64x32.sv
// 64x32 block-RAM stream FIFO controller with a 2-entry prefetch buffer (first word out 3 cycles after push, 1 word/cycle).
// in_ready drops only when the RAM holds 64 words; optional high-watermark output when IRAM_FIFO_HWM_EN is defined.
module iram_fifo_ctl_64x32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  level,
  output logic        ram_ena,
  output logic        ram_wea,
  output logic [5:0]  ram_addra,
  output logic [31:0] ram_dia,
  output logic        ram_enb,
  output logic [5:0]  ram_addrb,
  input  logic [31:0] ram_dob
`ifdef IRAM_FIFO_HWM_EN
  ,
  output logic [6:0]  hwm
`endif
);

  logic [5:0]  wptr;
  logic [5:0]  rptr;
  logic [6:0]  ram_cnt;
  logic        inflight;
  logic [1:0]  buf_cnt;
  logic [31:0] obuf [2];

  logic        push;
  logic        pop;
  logic        rd;
  logic [2:0]  occ;
  logic        fill_hi;

  always_comb begin
    in_ready  = (ram_cnt != 7'd64);
    push      = in_valid & in_ready;
    out_valid = (buf_cnt != 2'd0);
    pop       = out_valid & out_ready;
    // Buffer slots already spoken for, counting the word returning from RAM this cycle.
    occ       = {1'b0, buf_cnt} + {2'b00, inflight};
    rd        = (ram_cnt != 7'd0) & ((occ < 3'd2) | ((occ == 3'd2) & pop));
    fill_hi   = (buf_cnt == 2'd2) | ((buf_cnt == 2'd1) & ~pop);
  end

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dia   = in_data;
  assign ram_enb   = rd;
  assign ram_addrb = rptr;
  assign out_data  = obuf[0];
  assign level     = ram_cnt + {6'd0, inflight} + {5'd0, buf_cnt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= 6'd0;
      rptr     <= 6'd0;
      ram_cnt  <= 7'd0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
    end else begin
      if (push) wptr <= wptr + 6'd1;
      if (rd)   rptr <= rptr + 6'd1;
      ram_cnt  <= ram_cnt + {6'd0, push} - {6'd0, rd};
      inflight <= rd;
      buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Returning word lands in the first free slot after this cycle's shift.
  always_ff @(posedge clk) begin
    if (pop) obuf[0] <= obuf[1];
    if (inflight) begin
      if (fill_hi) obuf[1] <= ram_dob;
      else         obuf[0] <= ram_dob;
    end
  end

`ifdef IRAM_FIFO_HWM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            hwm <= 7'd0;
    else if (level > hwm) hwm <= level;
  end
`endif

endmodule

// File: tb/tb_iram_fifo_ctl_64x32.sv
// Scoreboard bench for iram_fifo_ctl_64x32: queue reference model, behavioural 64x32 RAM, directed and random phases.
module tb_iram_fifo_ctl_64x32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [6:0]  level;
  logic        ram_ena, ram_wea, ram_enb;
  logic [5:0]  ram_addra, ram_addrb;
  logic [31:0] ram_dia;
  logic [31:0] ram_dob = 32'd0;
`ifdef IRAM_FIFO_HWM_EN
  logic [6:0]  hwm;
`endif

  always #5 clk = ~clk;

  iram_fifo_ctl_64x32 dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
`ifdef IRAM_FIFO_HWM_EN
    , .hwm(hwm)
`endif
  );

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [31:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: level must equal words accepted minus words popped; popped data must match FIFO order.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      check("level", {25'd0, level}, q.size());
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("pop_on_empty", {31'd0, out_valid}, 32'd0);
        else check("out_data", out_data, q.pop_front());
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_reset_outs(input string p);
    check({p, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({p, "_level"}, {25'd0, level}, 32'd0);
    check({p, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({p, "_ram_ena"}, {31'd0, ram_ena}, 32'd0);
    check({p, "_ram_wea"}, {31'd0, ram_wea}, 32'd0);
    check({p, "_ram_enb"}, {31'd0, ram_enb}, 32'd0);
    check({p, "_addra"}, {26'd0, ram_addra}, 32'd0);
    check({p, "_addrb"}, {26'd0, ram_addrb}, 32'd0);
`ifdef IRAM_FIFO_HWM_EN
    check({p, "_hwm"}, {25'd0, hwm}, 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int sent;
    int n;

    // Reset state
    repeat (1) @(posedge clk);
    #7;
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Single-word latency: push in cycle 0, visible in cycle 3, gone in cycle 4
    in_data = 32'h0000_0001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check("lat_valid", {31'd0, out_valid}, (c == 3) ? 32'd1 : 32'd0);
      check("lat_level", {25'd0, level}, (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
      if (c == 3) check("lat_data", out_data, 32'h0000_0001);
      step();
      in_valid = 1'b0;
    end

    // Fill to capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 66; i++) begin
      in_data = i;
      in_valid = 1'b1;
      @(negedge clk);
      check("fill_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_ram_ena", {31'd0, ram_ena}, 32'd0);
    check("full_level", {25'd0, level}, 32'd66);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("full_head_valid", {31'd0, out_valid}, 32'd1);
    check("full_head_data", out_data, 32'd0);
`ifdef IRAM_FIFO_HWM_EN
    check("hwm_full", {25'd0, hwm}, 32'd66);
`endif
    step();

    // Drain from full
    p0 = pops;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_enb", {31'd0, ram_enb}, 32'd1);
    check("drain_ready_before", {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clk);
    check("drain_ready_after", {31'd0, in_ready}, 32'd1);
    n = 0;
    while (pops - p0 < 66 && n < 200) begin
      step();
      n++;
    end
    check("drain_pops", pops - p0, 32'd66);
    step();
    check("drain_empty_valid", {31'd0, out_valid}, 32'd0);

    // Continuous streaming across pointer wrap
    p0 = pops;
    first_pop = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = 32'h1000 + i;
      @(negedge clk);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (pops - p0 < 200 && n < 50) begin
      step();
      n++;
    end
    check("stream_pops", pops - p0, 32'd200);
    check("stream_gapless", last_pop - first_pop, 32'd199);

    // Random traffic
    sent = 0;
    n = 0;
    while (sent < 10000 && n < 60000) begin
      in_valid = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      in_data = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("rand_sent", sent, 32'd10000);
    check("rand_drained", q.size(), 32'd0);
    check("rand_level", {25'd0, level}, 32'd0);

    // Reset with a read in flight and level 10
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_data = 32'h200 + i;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rd", {31'd0, ram_enb}, 32'd1);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_level", {25'd0, level}, 32'd10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("mid_rst");
    step();
    reset = 1'b0;
    in_data = 32'hA5A5_A5A5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_valid", {31'd0, out_valid}, 32'd1);
    check("mid_first_data", out_data, 32'hA5A5_A5A5);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
